// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter in front of one RAM port
// Registered RAM command outputs; read data returned in issue order through a tag pipe.
module ram_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_wd,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_last_id;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_a;
  logic [DW-1:0] r_ram_wd;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic [RD_LAT:0] r_tag_v;
  logic [RD_LAT:0] r_tag_id;

  logic          w_elig0;
  logic          w_elig1;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_acc;
  logic          w_cmd_we;
  logic [AW-1:0] w_cmd_a;
  logic [DW-1:0] w_cmd_wd;
  logic          w_push_v;
  logic          w_ret0;
  logic          w_ret1;

  // A requester in its own gnt cycle is still showing the accepted command, so it sits out.
  assign w_elig0 = req0 & ~r_gnt0;
  assign w_elig1 = req1 & ~r_gnt1;

  // r_last_id names the most recent winner; the other side takes a tie.
  assign w_acc0   = w_elig0 & (~w_elig1 | r_last_id);
  assign w_acc1   = w_elig1 & ~w_acc0;
  assign w_acc    = w_acc0 | w_acc1;

  assign w_cmd_we = w_acc1 ? we1    : we0;
  assign w_cmd_a  = w_acc1 ? addr1  : addr0;
  assign w_cmd_wd = w_acc1 ? wdata1 : wdata0;
  assign w_push_v = w_acc & ~w_cmd_we;

  // Last tag stage lines up with the cycle ram_rdata is valid for that read.
  assign w_ret0 = r_tag_v[RD_LAT] & ~r_tag_id[RD_LAT];
  assign w_ret1 = r_tag_v[RD_LAT] &  r_tag_id[RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_last_id <= 1'b1;
      r_ram_we  <= 1'b0;
      r_ram_a   <= '0;
      r_ram_wd  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_tag_v   <= '0;
      r_tag_id  <= '0;
    end else begin
      r_gnt0   <= w_acc0;
      r_gnt1   <= w_acc1;
      r_ram_we <= w_acc & w_cmd_we;
      if (w_acc) begin
        r_ram_a   <= w_cmd_a;
        r_ram_wd  <= w_cmd_wd;
        r_last_id <= w_acc1;
      end
      r_tag_v   <= {r_tag_v[RD_LAT-1:0], w_push_v};
      r_tag_id  <= {r_tag_id[RD_LAT-1:0], w_acc1};
      r_rvalid0 <= w_ret0;
      r_rvalid1 <= w_ret1;
      if (w_ret0) begin
        r_rdata0 <= ram_rdata;
      end
      if (w_ret1) begin
        r_rdata1 <= ram_rdata;
      end
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign ram_a   = r_ram_a;
  assign ram_wd  = r_ram_wd;
  assign ram_we  = r_ram_we;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign busy    = |r_tag_v;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench driving RD_LAT=1 and RD_LAT=3 arbiters in lockstep
module tb_ram_port_arbiter;

  typedef struct {
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
  } cmd_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;

  logic       gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, ram_we_a, busy_a;
  logic [7:0] rdata0_a, rdata1_a, ram_a_a, ram_wd_a, ram_rdata_a;
  logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, ram_we_b, busy_b;
  logic [7:0] rdata0_b, rdata1_b, ram_a_b, ram_wd_b, ram_rdata_b;

  ram_port_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
    .ram_a(ram_a_a), .ram_wd(ram_wd_a), .ram_we(ram_we_a),
    .ram_rdata(ram_rdata_a), .busy(busy_a)
  );

  ram_port_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .ram_a(ram_a_b), .ram_wd(ram_wd_b), .ram_we(ram_we_b),
    .ram_rdata(ram_rdata_b), .busy(busy_b)
  );

  // RAM port: address/data/we registered, read data combinational from the registered address;
  // the RD_LAT=3 copy adds two output stages.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] ra_a, ra_b;
  logic [7:0] pipe_b [2];

  always @(posedge clk) begin
    ra_a <= ram_a_a;
    if (ram_we_a) mem_a[ram_a_a] <= ram_wd_a;
  end
  assign ram_rdata_a = mem_a[ra_a];

  always @(posedge clk) begin
    ra_b <= ram_a_b;
    if (ram_we_b) mem_b[ram_a_b] <= ram_wd_b;
    pipe_b[0] <= mem_b[ra_b];
    pipe_b[1] <= pipe_b[0];
  end
  assign ram_rdata_b = pipe_b[1];

  cmd_t q0[$];
  cmd_t q1[$];
  rd_t  sb_a[$];
  rd_t  sb_b[$];
  logic [7:0] shadow [256];

  logic       m_gnt0, m_gnt1, m_last, m_we;
  logic [7:0] m_ra, m_wd;
  logic [7:0] m_rd0 [2];
  logic [7:0] m_rd1 [2];
  int         cyc;
  int         n_vec;
  int         n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic present();
    if (q0.size() != 0) begin
      req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].a; wdata0 = q0[0].d;
    end else begin
      req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    end
    if (q1.size() != 0) begin
      req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].a; wdata1 = q1[0].d;
    end else begin
      req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    end
  endtask

  task automatic check_port(input int k, input string sfx,
                            input logic g0, input logic g1, input logic we,
                            input logic [7:0] a, input logic [7:0] wd,
                            input logic rv0, input logic rv1,
                            input logic [7:0] rd0, input logic [7:0] rd1, input logic bsy);
    logic exp0, exp1;
    int   pend;
    rd_t  r;
    exp0 = 1'b0;
    exp1 = 1'b0;
    if (k == 0) begin
      if (sb_a.size() != 0 && sb_a[0].due == cyc) begin
        r = sb_a.pop_front();
        if (r.id) begin exp1 = 1'b1; m_rd1[0] = r.data; end
        else      begin exp0 = 1'b1; m_rd0[0] = r.data; end
      end
      pend = sb_a.size();
    end else begin
      if (sb_b.size() != 0 && sb_b[0].due == cyc) begin
        r = sb_b.pop_front();
        if (r.id) begin exp1 = 1'b1; m_rd1[1] = r.data; end
        else      begin exp0 = 1'b1; m_rd0[1] = r.data; end
      end
      pend = sb_b.size();
    end
    check({sfx, "_gnt0"},    g0,  m_gnt0);
    check({sfx, "_gnt1"},    g1,  m_gnt1);
    check({sfx, "_ram_we"},  we,  m_we);
    check({sfx, "_ram_a"},   a,   m_ra);
    check({sfx, "_ram_wd"},  wd,  m_wd);
    check({sfx, "_rvalid0"}, rv0, exp0);
    check({sfx, "_rvalid1"}, rv1, exp1);
    check({sfx, "_rdata0"},  rd0, m_rd0[k]);
    check({sfx, "_rdata1"},  rd1, m_rd1[k]);
    check({sfx, "_busy"},    bsy, (pend != 0));
  endtask

  task automatic tick();
    logic e0, e1, a0, a1;
    cmd_t c;
    e0 = req0 & ~m_gnt0;
    e1 = req1 & ~m_gnt1;
    a0 = e0 & (~e1 | m_last);
    a1 = e1 & ~a0;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_we = 1'b0; m_last = 1'b1;
      m_ra = 8'h00; m_wd = 8'h00;
      m_rd0[0] = 8'h00; m_rd0[1] = 8'h00; m_rd1[0] = 8'h00; m_rd1[1] = 8'h00;
      sb_a.delete();
      sb_b.delete();
    end else begin
      m_gnt0 = a0;
      m_gnt1 = a1;
      m_we   = 1'b0;
      if (a0 | a1) begin
        if (a0) c = q0.pop_front();
        else    c = q1.pop_front();
        m_last = a1;
        m_ra   = c.a;
        m_wd   = c.d;
        m_we   = c.we;
        if (c.we) begin
          shadow[c.a] = c.d;
        end else begin
          sb_a.push_back('{a1, shadow[c.a], cyc + 2});
          sb_b.push_back('{a1, shadow[c.a], cyc + 4});
        end
      end
    end
    check_port(0, "l1", gnt0_a, gnt1_a, ram_we_a, ram_a_a, ram_wd_a,
               rvalid0_a, rvalid1_a, rdata0_a, rdata1_a, busy_a);
    check_port(1, "l3", gnt0_b, gnt1_b, ram_we_b, ram_a_b, ram_wd_b,
               rvalid0_b, rvalid1_b, rdata0_b, rdata1_b, busy_b);
    present();
  endtask

  task automatic drain();
    int n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < 200) begin
      tick();
      n++;
      pending = (q0.size() != 0) || (q1.size() != 0) || (sb_a.size() != 0) || (sb_b.size() != 0);
    end
    check("drain_idle", pending, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i]  = 8'(i * 7 + 3);
      mem_b[i]  = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    mem_a[8'h7F] = 8'h3C; mem_b[8'h7F] = 8'h3C; shadow[8'h7F] = 8'h3C;
    m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_we = 1'b0; m_last = 1'b1;
    m_ra = 8'h00; m_wd = 8'h00;
    m_rd0[0] = 8'h00; m_rd0[1] = 8'h00; m_rd1[0] = 8'h00; m_rd1[1] = 8'h00;
    rst_n = 1'b0;
    present();
    repeat (3) tick();
    rst_n = 1'b1;

    // write then read back the same address
    q0.push_back('{1'b1, 8'h10, 8'hA5});
    present();
    drain();
    q0.push_back('{1'b0, 8'h10, 8'h00});
    present();
    drain();

    // both held continuously with reads, fresh from reset so requester 0 leads
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q0.push_back('{1'b0, 8'(i), 8'h00});
      q1.push_back('{1'b0, 8'(8'h40 + i), 8'h00});
    end
    present();
    drain();

    // write by requester 1 immediately followed by read of the same address by requester 0
    q1.push_back('{1'b1, 8'h20, 8'h5A});
    present();
    tick();
    q0.push_back('{1'b0, 8'h20, 8'h00});
    present();
    drain();

    // reset with two reads in flight, then a tie
    q0.push_back('{1'b0, 8'h10, 8'h00});
    q1.push_back('{1'b0, 8'h20, 8'h00});
    present();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    q0.push_back('{1'b0, 8'h30, 8'h00});
    q1.push_back('{1'b0, 8'h31, 8'h00});
    present();
    drain();

    // preloaded address, then back-to-back reads from both sides
    q0.push_back('{1'b0, 8'h7F, 8'h00});
    present();
    drain();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 8'(8'h7F - i), 8'h00});
      q1.push_back('{1'b0, 8'(8'h60 + i), 8'h00});
    end
    present();
    drain();

    // write-only burst, then read it back
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b1, 8'(8'h80 + i), 8'(8'hC0 + i)});
      q1.push_back('{1'b1, 8'(8'h90 + i), 8'(8'hD0 + i)});
    end
    present();
    drain();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 8'(8'h90 + i), 8'h00});
      q1.push_back('{1'b0, 8'(8'h80 + i), 8'h00});
    end
    present();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the 256x8 dual-port RAM between two requesters (requester 0, requester 1).
- Round-robin arbitration, req/gnt handshake, registered RAM-side command outputs, in-order read-data return.
- Sits between client logic and one RAM port; the RAM port itself is unchanged: address/data/we registered at the RAM, read data combinational from the registered address.

Parameters:
AW, 8, address width
DW, 8, data width
RD_LAT, 1, cycles from arbiter command output to valid ram_rdata at the RAM; legal 1..4

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
req0  in  1  requester 0 request; held with we0/addr0/wdata0 stable until gnt0
we0  in  1  1 = write, 0 = read
addr0  in  AW  requester 0 address
wdata0  in  DW  requester 0 write data
gnt0  out  1  one-cycle accept pulse for requester 0
rvalid0  out  1  one-cycle read-data-valid pulse for requester 0
rdata0  out  DW  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
ram_a  out  AW  RAM port address
ram_wd  out  DW  RAM port write data
ram_we  out  1  RAM port write enable
ram_rdata  in  DW  RAM port read data
busy  out  1  1 while any read is in flight in the return pipe

Behaviour:
- Reset (rst_n=0 at posedge): gnt0/1, rvalid0/1, ram_we, busy <= 0; ram_a, ram_wd, rdata0/1 <= 0; return pipe cleared; round-robin pointer set so requester 0 wins the first tie.
- Eligibility in cycle N: requester i eligible iff req_i=1 and gnt_i=0. A request is never re-accepted in its own gnt cycle, so max per-requester rate is 1 per 2 cycles; aggregate rate is 1 per cycle.
- Arbitration: one eligible -> it wins. Both eligible -> the one not granted most recently wins. Pointer updates only on an accept.
- Accept of requester i in cycle N -> at posedge ending N: gnt_i<=1, ram_a<=addr_i, ram_wd<=wdata_i, ram_we<=we_i. No accept -> gnt0/1<=0, ram_we<=0, ram_a/ram_wd hold.
- gnt0 and gnt1 are never both 1 in the same cycle.
- Read issue: accepted read pushes {valid, id} into a RD_LAT+1 deep tag shift pipe. Writes push an invalid entry.
- Read return: command on RAM outputs in cycle N+1; ram_rdata valid in cycle N+1+RD_LAT. Arbiter registers it: rvalid_id=1 and rdata_id=ram_rdata in cycle N+2+RD_LAT. Total read latency req-accept to rvalid = RD_LAT+2 cycles.
- rdata_i holds its last value between pulses. rvalid0 and rvalid1 never both 1. Returns are strictly in issue order.
- Write/read ordering: single in-order command stream. Write to X accepted in N followed by read of X accepted in N+1 returns the new data.
- Write-only traffic produces no rvalid.
- busy=1 iff any valid entry is in the tag pipe.
- Reset mid-operation: in-flight reads are dropped, no rvalid after reset. A req held across reset is re-arbitrated normally from the first cycle with rst_n=1.
- req deasserted before gnt: the request is withdrawn and no side effects occur.

Test Plan:
- Reset, then req0 write addr=0x10 wdata=0xA5 -> gnt0 one cycle later, ram_a=0x10, ram_wd=0xA5, ram_we=1 for exactly one cycle, no rvalid0.
- After the write, req0 read addr=0x10 (RD_LAT=1) -> gnt0 at +1, rvalid0=1 with rdata0=0xA5 exactly 3 cycles after accept, busy=1 in between.
- req0 and req1 both held high continuously, all reads -> grants alternate 0,1,0,1 starting with requester 0; ram_we=0; rvalid order matches grant order.
- Requester 1 writes addr=0x20 data=0x5A while requester 0 reads 0x20 in the next cycle -> rvalid0 returns 0x5A.
- Two reads issued, rst_n pulsed low before the first return -> no rvalid0/rvalid1 after reset; all outputs 0; the next tie grants requester 0.
- RD_LAT=3 build: read of a preloaded address 0x7F=0x3C -> rvalid at accept+5 with 0x3C; back-to-back reads from both requesters return in order with no loss.
